key_4x4_scan: RTL and testbench
===============================

Name: key_4x4_scan

Overview:
- Synthesizable column-scan controller for the on-board 4x4 matrix keypad.
- Drives one column low at a time and samples the four pulled-up row lines.
- Debounces press and release, then reports a one-cycle event with the key index (0..15) and its press/release state.
- Sits between the keypad pins and the application logic; it is the scanning end that the behavioural keypad model answers.

Parameters:
- SCAN_TICKS, 50000, clock cycles per column slot (1 ms at 50 MHz); minimum 4.
- DEB_TICKS, 500000, cycles a row pattern must stay stable to confirm press or release (10 ms at 50 MHz).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Rst  in  1  synchronous reset, active-high.
- Key_Row  in  4  keypad row lines, active low, external pull-ups, asynchronous to Clk.
- Key_Col  out  4  column drive, exactly one bit low while scanning or holding.
- key_flag  out  1  one-cycle pulse, a confirmed press or release event.
- key_value  out  4  key index = row*4 + col; valid when key_flag=1, held until the next event.
- key_state  out  1  0 = pressed, 1 = released; updated together with key_flag.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high, on Rst. All state changes on the rising edge of Clk.
- Reset values: Key_Col=4'b1110, key_flag=0, key_value=0, key_state=1, state=SCAN, column index=0, all counters=0.
- Row synchronizer: Key_Row passes through a 2-flop synchronizer; all logic uses the synchronized value row_s.
- Slot counter: counts 0..SCAN_TICKS-1. row_s is sampled only when the counter equals SCAN_TICKS-1, so drive and synchronizer settling are covered.
- SCAN state:
  - At end of slot with row_s==4'hF: column index increments mod 4 (3 wraps to 0), Key_Col rotates, slot counter restarts.
  - At end of slot with row_s!=4'hF: latch col=current index, pattern=row_s, go to DEB_PRESS. The column stays driven.
- DEB_PRESS state:
  - Each cycle: if row_s!=pattern, reload pattern and clear the debounce counter.
  - If row_s==4'hF, return to SCAN with no event; the column index advances normally.
  - When the counter reaches DEB_TICKS-1 with a stable non-F pattern: row = index of the lowest zero bit in pattern.
  - On that cycle, next cycle key_flag=1, key_value={row,col}, key_state=0; go to HOLD.
- HOLD state:
  - Column stays driven.
  - Debounce counter runs only while row_s==4'hF and clears on any low bit.
  - When it reaches DEB_TICKS-1: next cycle key_flag=1, key_value unchanged, key_state=1; go to SCAN, resume at col+1 mod 4.
- Event latency: press event appears DEB_TICKS cycles after the last row bounce (±1); release event likewise after the last release bounce.
- Multiple keys:
  - Only one key is tracked at a time.
  - Same column, several rows low: the lowest row wins.
  - Other columns are not scanned while in DEB_PRESS or HOLD, so other keys are ignored until release.
- key_flag never asserts on two consecutive cycles.
- Every press event is followed by exactly one release event before the next press.
- Rst asserted mid-operation (any state) returns all outputs and state to the reset values on the next edge; no release event is emitted for an aborted press.
- Counter widths: $clog2 of the respective parameter. No counter overflows; each is cleared on every state change.

Decomposition:
- Package key_pkg: state enum (SCAN, DEB_PRESS, HOLD), KEY_ROWS=4, KEY_COLS=4, lowest-zero priority-encode function.
- Sub-module key_sync2: 4-bit, 2-flop synchronizer with reset value 4'hF. This is the only sub-module.

Test Plan (SCAN_TICKS=8, DEB_TICKS=64, keypad model attached):
- Reset held 3 cycles, then released, no key pressed -> Key_Col cycles 1110,1101,1011,0111,1110 every 8 cycles; key_flag stays 0.
- Press row1/col2 with 20 random bounces (<40 cycles each), held 300 cycles -> exactly one key_flag with key_value=6, key_state=0, 64±2 cycles after the last bounce; Key_Col stays 1011 while held.
- Release the same key with bounces -> one key_flag with key_value=6, key_state=1, 64±2 cycles after the last bounce; scanning resumes at Key_Col=0111.
- Glitch: row0 low for 30 cycles while col0 is driven -> no key_flag; scanning resumes.
- Rows 1 and 3 low together on col3 -> press event key_value=7 (row 1 wins).
- Sweep all 16 keys as the model does -> 32 events, values 0..15 in order, press/release alternating; Rst asserted during HOLD -> outputs return to reset values next cycle and no release event follows.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and helpers for the 4x4 keypad column-scan controller.
package key_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    // SCAN walks the columns, DEB_PRESS confirms a press, HOLD waits for release.
    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HOLD      = 2'd2
    } key_fsm_t;

    // Index of the lowest low (pressed) row bit; the lowest row wins when
    // several keys of one column are down. An all-ones pattern never reaches
    // the caller, it maps to row 0.
    function automatic logic [1:0] lowest_zero(input logic [KEY_ROWS-1:0] pattern);
        logic [1:0] row;
        casez (pattern)
            4'b???0: row = 2'd0;
            4'b??01: row = 2'd1;
            4'b?011: row = 2'd2;
            4'b0111: row = 2'd3;
            default: row = 2'd0;
        endcase
        return row;
    endfunction

endpackage

// File: rtl/key_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Resets to all-ones so an idle (released) keypad is seen during reset.
module key_sync2
    import key_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_ROWS-1:0] row_raw,
    output logic [KEY_ROWS-1:0] row_sync
);

    logic [KEY_ROWS-1:0] meta;

    // Shift the raw rows through two flops to settle metastability.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so both flops
        // sample their inputs from before the edge; blocking would collapse
        // the chain into a single flop.
        if (rst) begin
            meta     <= '1;
            row_sync <= '1;
        end else begin
            meta     <= row_raw;
            row_sync <= meta;
        end
    end

endmodule

// File: rtl/key_4x4_scan.sv
// Column-scan controller for a 4x4 matrix keypad: drives one column low at a
// time, samples the pulled-up rows at the end of each slot, debounces press
// and release, and emits a one-cycle event with key index and press/release.
module key_4x4_scan
    import key_pkg::*;
#(
    parameter int SCAN_TICKS = 50000,
    parameter int DEB_TICKS  = 500000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] Key_Row,
    output logic [3:0] Key_Col,
    output logic       key_flag,
    output logic [3:0] key_value,
    output logic       key_state
);

    localparam int SW = $clog2(SCAN_TICKS);
    localparam int DW = $clog2(DEB_TICKS);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);

    // Synchronized row lines; all decisions below use only this value.
    logic [KEY_ROWS-1:0] row_s;

    key_sync2 u_sync (
        .clk      (Clk),
        .rst      (Rst),
        .row_raw  (Key_Row),
        .row_sync (row_s)
    );

    // Registered state and its next-state values.
    key_fsm_t            state,    state_nxt;
    logic [1:0]          col_idx,  col_nxt;
    logic [SW-1:0]       slot_cnt, slot_nxt;
    logic [DW-1:0]       deb_cnt,  deb_nxt;
    logic [KEY_ROWS-1:0] pattern,  pattern_nxt;
    logic                flag_nxt;
    logic [3:0]          value_nxt;
    logic                kstate_nxt;

    // Column drive follows the column index; the column stays driven while
    // a key is being debounced or held because col_idx does not move then.
    assign Key_Col = ~(4'b0001 << col_idx);

    // State register with synchronous reset to the idle scanning state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            slot_cnt  <= '0;
            deb_cnt   <= '0;
            pattern   <= '1;
            key_flag  <= 1'b0;
            key_value <= 4'd0;
            key_state <= 1'b1;
        end else begin
            state     <= state_nxt;
            col_idx   <= col_nxt;
            slot_cnt  <= slot_nxt;
            deb_cnt   <= deb_nxt;
            pattern   <= pattern_nxt;
            key_flag  <= flag_nxt;
            key_value <= value_nxt;
            key_state <= kstate_nxt;
        end
    end

    // Next-state logic: slot timing, press debounce and release debounce.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_nxt   = state;
        col_nxt     = col_idx;
        slot_nxt    = slot_cnt;
        deb_nxt     = deb_cnt;
        pattern_nxt = pattern;
        flag_nxt    = 1'b0;
        value_nxt   = key_value;
        kstate_nxt  = key_state;

        case (state)
            SCAN: begin
                // Rows are looked at only on the last cycle of a slot so the
                // column drive and the synchronizer have settled.
                if (slot_cnt == SLOT_LAST) begin
                    slot_nxt = '0;
                    if (row_s == 4'hF) begin
                        col_nxt = col_idx + 2'd1;
                    end else begin
                        pattern_nxt = row_s;
                        deb_nxt     = '0;
                        state_nxt   = DEB_PRESS;
                    end
                end else begin
                    slot_nxt = slot_cnt + SW'(1);
                end
            end

            DEB_PRESS: begin
                if (row_s == 4'hF) begin
                    // Contact opened before it was confirmed: a glitch or a
                    // bounce. Carry on scanning from the next column.
                    state_nxt = SCAN;
                    col_nxt   = col_idx + 2'd1;
                    slot_nxt  = '0;
                    deb_nxt   = '0;
                end else if (row_s != pattern) begin
                    pattern_nxt = row_s;
                    deb_nxt     = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    flag_nxt   = 1'b1;
                    value_nxt  = {lowest_zero(pattern), col_idx};
                    kstate_nxt = 1'b0;
                    state_nxt  = HOLD;
                    deb_nxt    = '0;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end

            HOLD: begin
                // Count only while every row is high; any low bit is a
                // bounce or the key still being held.
                if (row_s != 4'hF) begin
                    deb_nxt = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    flag_nxt   = 1'b1;
                    kstate_nxt = 1'b1;
                    state_nxt  = SCAN;
                    col_nxt    = col_idx + 2'd1;
                    slot_nxt   = '0;
                    deb_nxt    = '0;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end

            default: begin
                state_nxt = SCAN;
                slot_nxt  = '0;
                deb_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_4x4_scan.sv
// Self-checking bench for key_4x4_scan with a behavioural keypad attached.
module tb_key_4x4_scan;

    localparam int SCAN_TICKS = 8;
    localparam int DEB_TICKS  = 64;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [3:0]  Key_Row;
    logic [3:0]  Key_Col;
    logic        key_flag;
    logic [3:0]  key_value;
    logic        key_state;
    logic [15:0] keys_down;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] value;
        logic       state;
        logic [3:0] col;
    } ev_t;

    ev_t ev_q[$];
    int  flag_runs = 0;
    logic prev_flag = 1'b0;

    typedef struct packed {
        logic [3:0] key;
        logic [3:0] exp_value;
        logic [3:0] exp_col;
    } sweep_t;

    sweep_t sweep_tbl [16];
    logic [3:0] col_tbl [5];

    key_4x4_scan #(
        .SCAN_TICKS (SCAN_TICKS),
        .DEB_TICKS  (DEB_TICKS)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Key_Row   (Key_Row),
        .Key_Col   (Key_Col),
        .key_flag  (key_flag),
        .key_value (key_value),
        .key_state (key_state)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Keypad: a held key pulls its row low while its column is driven low.
    always_comb begin
        Key_Row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[r*4 + c] && !Key_Col[c]) Key_Row[r] = 1'b0;
    end

    // Event recorder, sampled mid-cycle.
    always @(negedge Clk) begin
        if (key_flag) ev_q.push_back('{cyc, key_value, key_state, Key_Col});
        if (key_flag && prev_flag) flag_runs++;
        prev_flag = key_flag;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic wait_events(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge Clk);
            if (ev_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns on the negedge right after Key_Col switched to target.
    task automatic wait_col_start(input logic [3:0] target, input int budget, output bit ok);
        logic [3:0] prev;
        ok = 1'b0;
        @(negedge Clk);
        prev = Key_Col;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (Key_Col == target && prev != target) begin
                ok = 1'b1;
                break;
            end
            prev = Key_Col;
        end
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int n0, p0, r0, bad;

        sweep_tbl = '{
            '{4'd0,  4'd0,  4'b1110}, '{4'd1,  4'd1,  4'b1101},
            '{4'd2,  4'd2,  4'b1011}, '{4'd3,  4'd3,  4'b0111},
            '{4'd4,  4'd4,  4'b1110}, '{4'd5,  4'd5,  4'b1101},
            '{4'd6,  4'd6,  4'b1011}, '{4'd7,  4'd7,  4'b0111},
            '{4'd8,  4'd8,  4'b1110}, '{4'd9,  4'd9,  4'b1101},
            '{4'd10, 4'd10, 4'b1011}, '{4'd11, 4'd11, 4'b0111},
            '{4'd12, 4'd12, 4'b1110}, '{4'd13, 4'd13, 4'b1101},
            '{4'd14, 4'd14, 4'b1011}, '{4'd15, 4'd15, 4'b0111}
        };
        col_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        keys_down = '0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        check("reset Key_Col", Key_Col, 4'b1110);
        check("reset key_flag", key_flag, 1'b0);
        check("reset key_value", key_value, 4'd0);
        check("reset key_state", key_state, 1'b1);
        Rst = 1'b0;

        // Idle scanning: sample the middle of each 8-cycle slot.
        repeat (4) @(negedge Clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("idle col slot %0d", i), Key_Col, col_tbl[i]);
            repeat (8) @(negedge Clk);
        end
        check("idle no events", ev_q.size(), 0);

        // Press row1/col2 with bounces; final contact aligned to a col2 slot start.
        n0 = ev_q.size();
        for (int b = 0; b < 20; b++) begin
            keys_down[6] = ~keys_down[6];
            repeat ($urandom_range(39, 1)) @(negedge Clk);
        end
        keys_down[6] = 1'b0;
        repeat (3) @(negedge Clk);
        wait_col_start(4'b1011, 64, ok);
        check("press col2 align", ok, 1'b1);
        keys_down[6] = 1'b1;
        p0 = cyc;
        wait_events(n0 + 1, 200, ok);
        check("press event timeout", ok, 1'b1);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (Key_Col != 4'b1011) bad++;
        end
        check("press hold col moves", bad, 0);
        check("press event count", ev_q.size(), n0 + 1);
        if (ev_q.size() > n0) begin
            check("press value", ev_q[n0].value, 4'd6);
            check("press state", ev_q[n0].state, 1'b0);
            check_range("press latency", ev_q[n0].cyc - p0,
                        SCAN_TICKS + DEB_TICKS - 2, SCAN_TICKS + DEB_TICKS + 2);
        end

        // Release with bounces; last edge is the final opening.
        n0 = ev_q.size();
        for (int b = 0; b < 20; b++) begin
            keys_down[6] = ~keys_down[6];
            repeat ($urandom_range(39, 1)) @(negedge Clk);
        end
        keys_down[6] = 1'b0;
        r0 = cyc;
        wait_events(n0 + 1, 200, ok);
        check("release event timeout", ok, 1'b1);
        repeat (100) @(negedge Clk);
        check("release event count", ev_q.size(), n0 + 1);
        if (ev_q.size() > n0) begin
            check("release value", ev_q[n0].value, 4'd6);
            check("release state", ev_q[n0].state, 1'b1);
            check("release resume col", ev_q[n0].col, 4'b0111);
            check_range("release latency", ev_q[n0].cyc - r0, DEB_TICKS, DEB_TICKS + 4);
        end

        // Glitch: row0 low for 30 cycles on col0.
        n0 = ev_q.size();
        wait_col_start(4'b1110, 64, ok);
        check("glitch col0 align", ok, 1'b1);
        keys_down[0] = 1'b1;
        repeat (30) @(negedge Clk);
        keys_down[0] = 1'b0;
        wait_col_start(4'b1011, 64, ok);
        check("glitch scan resumes", ok, 1'b1);
        repeat (100) @(negedge Clk);
        check("glitch no event", ev_q.size(), n0);

        // Rows 1 and 3 on col3 together: row 1 wins.
        n0 = ev_q.size();
        keys_down[7]  = 1'b1;
        keys_down[15] = 1'b1;
        wait_events(n0 + 1, 200, ok);
        check("multi press timeout", ok, 1'b1);
        @(negedge Clk);
        keys_down = '0;
        wait_events(n0 + 2, 200, ok);
        check("multi release timeout", ok, 1'b1);
        if (ev_q.size() > n0 + 1) begin
            check("multi press value", ev_q[n0].value, 4'd7);
            check("multi press state", ev_q[n0].state, 1'b0);
            check("multi release value", ev_q[n0+1].value, 4'd7);
            check("multi release state", ev_q[n0+1].state, 1'b1);
        end

        // Sweep every key.
        p0 = ev_q.size();
        for (int k = 0; k < 16; k++) begin
            n0 = ev_q.size();
            @(negedge Clk);
            keys_down = '0;
            keys_down[sweep_tbl[k].key] = 1'b1;
            wait_events(n0 + 1, 200, ok);
            check($sformatf("sweep %0d press timeout", k), ok, 1'b1);
            repeat (10) @(negedge Clk);
            check($sformatf("sweep %0d hold col", k), Key_Col, sweep_tbl[k].exp_col);
            keys_down = '0;
            wait_events(n0 + 2, 200, ok);
            check($sformatf("sweep %0d release timeout", k), ok, 1'b1);
            if (ev_q.size() > n0 + 1) begin
                check($sformatf("sweep %0d press value", k), ev_q[n0].value, sweep_tbl[k].exp_value);
                check($sformatf("sweep %0d press state", k), ev_q[n0].state, 1'b0);
                check($sformatf("sweep %0d press col", k), ev_q[n0].col, sweep_tbl[k].exp_col);
                check($sformatf("sweep %0d release value", k), ev_q[n0+1].value, sweep_tbl[k].exp_value);
                check($sformatf("sweep %0d release state", k), ev_q[n0+1].state, 1'b1);
            end
        end
        repeat (10) @(negedge Clk);
        check("sweep event count", ev_q.size(), p0 + 32);

        // Reset while holding key 9: no release event afterwards.
        n0 = ev_q.size();
        @(negedge Clk);
        keys_down[9] = 1'b1;
        wait_events(n0 + 1, 200, ok);
        check("rst press timeout", ok, 1'b1);
        repeat (20) @(negedge Clk);
        check("rst pre value", key_value, 4'd9);
        Rst = 1'b1;
        keys_down = '0;
        @(negedge Clk);
        check("rst Key_Col", Key_Col, 4'b1110);
        check("rst key_flag", key_flag, 1'b0);
        check("rst key_value", key_value, 4'd0);
        check("rst key_state", key_state, 1'b1);
        Rst = 1'b0;
        repeat (300) @(negedge Clk);
        check("rst no release", ev_q.size(), n0 + 1);

        check("flag never back-to-back", flag_runs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
